// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch; FETCH_ALIGN_CHECK_EN rejects misaligned fetch addresses.
// Latency: fetch_go at E0, mem_ack earliest at E1, IR_Wr the cycle after E1 (3 cycles per fetch minimum).
// Backpressure: REQ holds mem_req/mem_addr until mem_ack; fetch_go and pc_load are ignored while busy.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_go,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic        IR_Wr,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] fetch_pc;
  logic        misaligned;

  // A redirect in the same cycle as fetch_go steers the fetch to the new target.
  assign fetch_pc = pc_load ? pc_next : pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = (fetch_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && fetch_go && misaligned;
    end
  end

  assign fetch_err = err_q;
  assign mem_addr  = pc_q;
`else
  assign misaligned = 1'b0;
  assign fetch_err  = 1'b0;
  assign mem_addr   = {pc_q[31:2], 2'b00};
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    inst_nxt  = inst_q;
    case (state)
      IDLE: begin
        if (pc_load) begin
          pc_nxt = pc_next;
        end
        if (fetch_go && !misaligned) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          inst_nxt  = mem_rdata;
          pc_nxt    = pc_q + 32'd4;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      inst_q <= 32'h0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      inst_q <= inst_nxt;
    end
  end

  assign mem_req = (state == REQ);
  assign IR_Wr   = (state == DONE);
  assign busy    = (state != IDLE);
  assign pc      = pc_q;
  assign inst    = inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: transaction-level model compared every cycle plus literal spot checks.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_go = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] inst;
  logic        IR_Wr;
  logic [31:0] pc;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_go  (fetch_go),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .inst      (inst),
    .IR_Wr     (IR_Wr),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one fetch in flight, an IR pulse owed after completion, an error pulse owed.
  logic [31:0] m_pc, m_inst, m_addr, m_a;
  bit          m_inflight, m_irwr, m_err, m_nir, m_nerr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc       = RST_PC;
      m_inst     = 32'h0;
      m_addr     = 32'h0;
      m_inflight = 1'b0;
      m_irwr     = 1'b0;
      m_err      = 1'b0;
    end else begin
      m_nir  = 1'b0;
      m_nerr = 1'b0;
      if (m_inflight) begin
        if (mem_ack) begin
          m_inst     = mem_rdata;
          m_pc       = m_pc + 32'd4;
          m_inflight = 1'b0;
          m_nir      = 1'b1;
        end
      end else if (!m_irwr) begin
        m_a = pc_load ? pc_next : m_pc;
        if (pc_load) m_pc = pc_next;
        if (fetch_go) begin
          if (ALIGN && (m_a[1:0] != 2'b00)) begin
            m_nerr = 1'b1;
          end else begin
            m_inflight = 1'b1;
            m_addr     = ALIGN ? m_a : {m_a[31:2], 2'b00};
          end
        end
      end
      m_irwr = m_nir;
      m_err  = m_nerr;
    end
  end

  int          ir_cnt = 0;
  int          req_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_addr = 32'h0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("mem_req", mem_req, m_inflight);
      if (m_inflight) chk32("mem_addr", mem_addr, m_addr);
      chk1("IR_Wr", IR_Wr, m_irwr);
      chk1("busy", busy, m_inflight || m_irwr);
      chk1("fetch_err", fetch_err, m_err);
      chk32("pc", pc, m_pc);
      chk32("inst", inst, m_inst);
      if (IR_Wr) ir_cnt++;
      if (fetch_err) err_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_addr = mem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ir_cnt  = 0;
    req_cnt = 0;
    err_cnt = 0;
    last_addr = 32'hFFFF_FFFF;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk32("rst_pc", pc, RST_PC);
    chk32("rst_inst", inst, 32'h0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_IR_Wr", IR_Wr, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_fetch_err", fetch_err, 1'b0);
    rst_n = 1'b1;

    // Basic fetch with mem_ack held high.
    clr();
    mem_ack = 1'b1; mem_rdata = 32'h2408_0005; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
    chk32("t1_addr", last_addr, 32'h0000_3000);
    chk32("t1_ir_cnt", 32'(ir_cnt), 32'd1);
    chk32("t1_inst", inst, 32'h2408_0005);
    chk32("t1_pc", pc, 32'h0000_3004);

    // mem_ack delayed by 4 cycles; fetch_go and pc_load pulses while busy are ignored.
    clr();
    mem_rdata = 32'hDEAD_0001; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_go = i[0];
      pc_load  = ~i[0];
      pc_next  = 32'h1234_5678;
      tick();
    end
    fetch_go = 1'b0; pc_load = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    repeat (2) tick();
    chk32("t2_req_cycles", 32'(req_cnt), 32'd5);
    chk32("t2_addr", last_addr, 32'h0000_3004);
    chk32("t2_ir_cnt", 32'(ir_cnt), 32'd1);
    chk32("t2_pc", pc, 32'h0000_3008);
    chk32("t2_inst", inst, 32'hDEAD_0001);

    // Redirect and fetch in the same cycle.
    clr();
    pc_next = 32'h0000_3100; pc_load = 1'b1; fetch_go = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_00AA;
    tick();
    pc_load = 1'b0; fetch_go = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
    chk32("t3_addr", last_addr, 32'h0000_3100);
    chk32("t3_pc", pc, 32'h0000_3104);

    // PC wrap at the top of the address space.
    clr();
    pc_next = 32'hFFFF_FFFC; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    chk32("t4_pc_loaded", pc, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
    chk32("t4_ir_cnt", 32'(ir_cnt), 32'd1);
    chk32("t4_pc_wrap", pc, 32'h0000_0000);

    // Reset during REQ, late mem_ack ignored.
    clr();
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    chk1("t5_in_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t5_req_drop", mem_req, 1'b0);
    chk1("t5_busy_drop", busy, 1'b0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    mem_ack = 1'b0;
    chk32("t5_ir_cnt", 32'(ir_cnt), 32'd0);
    chk32("t5_pc", pc, RST_PC);
    chk32("t5_inst", inst, 32'h0);

    // First fetch after reset comes from RESET_PC.
    clr();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
    chk32("t6_addr", last_addr, 32'h0000_3000);
    chk32("t6_pc", pc, 32'h0000_3004);

    // Misaligned fetch address.
    clr();
    pc_next = 32'h0000_3002; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h3333_4444; fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    repeat (3) tick();
    mem_ack = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk32("t7_err_cnt", 32'(err_cnt), 32'd1);
    chk32("t7_req_cnt", 32'(req_cnt), 32'd0);
    chk32("t7_ir_cnt", 32'(ir_cnt), 32'd0);
    chk32("t7_pc", pc, 32'h0000_3002);
    chk32("t7_inst", inst, 32'h1111_2222);
`else
    chk32("t7_err_cnt", 32'(err_cnt), 32'd0);
    chk32("t7_addr", last_addr, 32'h0000_3000);
    chk32("t7_ir_cnt", 32'(ir_cnt), 32'd1);
    chk32("t7_pc", pc, 32'h0000_3006);
    chk32("t7_inst", inst, 32'h3333_4444);
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
